// File: rtl/alu_input_seq.sv
// alu_input_seq: button-stepped A/B/op entry sequencer feeding registered operands to the board ALU
module alu_input_seq #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic       issue,
  output logic [1:0] state,
  output logic [7:0] issue_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_SHOW = 2'b11} state_t;
  state_t        state_q, state_d;
  logic          s1_q, s1_d, btn_s_q, btn_s_d;
  logic          stable_q, stable_d, stable_dly_q, stable_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          issue_q, issue_d;
  logic [7:0]    issue_cnt_q, issue_cnt_d;
  logic          press;
  // Two-flop synchronizer, then accept a new level only after it holds for DEBOUNCE_CYCLES cycles
  always_comb begin
    s1_d         = btn;
    btn_s_d      = s1_q;
    stable_dly_d = stable_q;
    stable_d     = (btn_s_q != stable_q && cnt_q == CNT_MAX) ? btn_s_q : stable_q;
    cnt_d        = (btn_s_q == stable_q || cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
  end
  assign press = stable_q & ~stable_dly_q;
  // Entry FSM: each accepted press latches the field for the current state and advances
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    issue_d     = 1'b0;
    issue_cnt_d = issue_cnt_q;
    if (press) begin
      case (state_q)
        S_A: begin
          a_d     = sw;
          state_d = S_B;
        end
        S_B: begin
          b_d     = sw;
          state_d = S_OP;
        end
        S_OP: begin
          op_d        = sw[2:0];
          issue_d     = 1'b1;
          issue_cnt_d = issue_cnt_q + 8'd1;
          state_d     = S_SHOW;
        end
        S_SHOW: state_d = S_A;
      endcase
    end
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      btn_s_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      state_q      <= S_A;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      issue_q      <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      btn_s_q      <= btn_s_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      issue_q      <= issue_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end
  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign issue     = issue_q;
  assign state     = state_q;
  assign issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_alu_input_seq.sv
// tb_alu_input_seq: scoreboard bench for the ALU entry sequencer with a press-level reference model
module tb_alu_input_seq;
  logic clk = 1'b0, rst = 1'b1, btn = 1'b0;
  logic [3:0] sw = 4'd0;
  logic [3:0] a, b;
  logic [2:0] op;
  logic issue;
  logic [1:0] state;
  logic [7:0] issue_cnt;
  int n_chk = 0, n_fail = 0, n_issue = 0, n_exp_issue = 0;
  int m_st = 0;
  logic [3:0] m_a = 0, m_b = 0;
  logic [2:0] m_op = 0;
  logic [7:0] m_cnt = 0;
  logic [18:0] exp_q[$];

  alu_input_seq #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .a(a), .b(b), .op(op),
    .issue(issue), .state(state), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // One accepted press: fields are entered A, B, op, then a show step, cyclically
  task automatic model_press(input logic [3:0] v);
    if (m_st == 0) m_a = v;
    else if (m_st == 1) m_b = v;
    else if (m_st == 2) begin
      m_op = v[2:0];
      m_cnt = m_cnt + 8'd1;
      n_exp_issue++;
      exp_q.push_back({m_a, m_b, m_op, m_cnt});
    end
    m_st = (m_st + 1) % 4;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_state"}, int'(state), m_st);
    chk({tag, "_a"}, int'(a), int'(m_a));
    chk({tag, "_b"}, int'(b), int'(m_b));
    chk({tag, "_op"}, int'(op), int'(m_op));
    chk({tag, "_issue_cnt"}, int'(issue_cnt), int'(m_cnt));
  endtask

  task automatic release_btn();
    @(negedge clk); btn = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // Clean press: rise just before edge 1, nothing changes through edge 6, update lands at edge 7
  task automatic press(input logic [3:0] v, input int hold);
    int old;
    @(negedge clk); sw = v; btn = 1'b1;
    old = m_st;
    model_press(v);
    repeat (6) @(posedge clk);
    #1 chk("pre_edge7_state", int'(state), old);
    @(posedge clk);
    #1 check_outs("edge7");
    chk("issue_at_edge7", int'(issue), (old == 2) ? 1 : 0);
    repeat (hold - 7) @(posedge clk);
    release_btn();
  endtask

  task automatic glitch();
    @(negedge clk); sw = 4'($urandom_range(0, 15)); btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(posedge clk);
    #1 check_outs("glitch");
  endtask

  task automatic bounce_hold(input logic [3:0] v);
    @(negedge clk); sw = v; btn = 1'b1;
    model_press(v);
    @(negedge clk); btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    repeat (50) @(negedge clk);
    #1 check_outs("bounce_hold");
    release_btn();
  endtask

  // Monitor: every issue pulse must match the oldest committed command
  always @(negedge clk) begin
    if (!rst && issue) begin
      n_issue++;
      if (exp_q.size() == 0) chk("issue_unexpected", 1, 0);
      else chk("issue_cmd", int'({a, b, op, issue_cnt}), int'(exp_q.pop_front()));
    end
  end

  initial begin
    int base;
    #1 check_outs("reset");
    chk("reset_issue", int'(issue), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    press(4'd3, 8);
    press(4'd6, 8);
    press(4'b1001, 8);
    chk("full_a", int'(a), 3);
    chk("full_b", int'(b), 6);
    chk("full_op", int'(op), 1);
    chk("full_cnt", int'(issue_cnt), 1);
    chk("full_state", int'(state), 3);
    press(4'($urandom_range(0, 15)), 8);
    glitch();
    press(4'($urandom_range(0, 15)), 10);
    bounce_hold(4'($urandom_range(0, 15)));
    press(4'($urandom_range(0, 15)), 8);
    press(4'($urandom_range(0, 15)), 8);
    press(4'd5, 8);
    @(negedge clk); #2 rst = 1'b1;
    model_reset();
    #1 check_outs("async_reset");
    chk("async_reset_issue", int'(issue), 0);
    @(negedge clk); rst = 1'b0;
    press(4'd7, 8);
    press(4'd2, 8);
    @(negedge clk); rst = 1'b1;
    model_reset();
    #1 check_outs("mid_entry_reset");
    @(negedge clk); rst = 1'b0;
    press(4'd9, 8);
    chk("after_reset_a", int'(a), 9);
    chk("after_reset_state", int'(state), 1);
    @(negedge clk); rst = 1'b1;
    model_reset();
    @(negedge clk); rst = 1'b0;
    base = n_issue;
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++) press(4'($urandom_range(0, 15)), 8);
    chk("wrap_cnt", int'(issue_cnt), 0);
    chk("wrap_pulses", n_issue - base, 256);
    check_outs("wrap_final");
    repeat (4) @(negedge clk);
    chk("total_pulses", n_issue, n_exp_issue);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
